eth_fifo_pkt_reader: RTL and testbench

Downstream consumer of the 8-bit, 2048-deep synchronous Ethernet FIFO. It tracks FIFO occupancy and decides when a UDP payload is ready: either a full packet of PKT_MAX bytes is stored, or data has sat idle for TIMEOUT cycles. It then launches the UDP TX engine and streams FIFO bytes to it on the engine's byte-request handshake.

---
 rtl/eth_fifo_pkt_reader.sv | 167 ++++++++++++++++
 tb/tb_eth_fifo_pkt_reader.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_fifo_pkt_reader.sv
// eth_fifo_pkt_reader: drains an 8-bit Ethernet FIFO into the UDP TX engine.
// Launches a packet when PKT_MAX bytes are stored or data has sat idle for
// TIMEOUT cycles, then streams bytes on the engine's tx_req handshake.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   fifo_wr_en          mirror of upstream FIFO write strobe
//   fifo_full/empty     FIFO status flags
//   fifo_rd_en          FIFO read enable (combinational from tx_req)
//   fifo_rd_data        FIFO read data, valid 1 cycle after fifo_rd_en
//   tx_start_en         one-cycle packet launch pulse
//   tx_byte_num         payload length, held until next launch
//   tx_req, tx_done     UDP TX byte request / packet complete
//   tx_data             payload byte (pass-through of fifo_rd_data)
//   busy                high outside IDLE
//   underrun            pulse: byte requested while FIFO empty
module eth_fifo_pkt_reader #(
    parameter int PKT_MAX = 1024,
    parameter int TIMEOUT = 125000,
    parameter int DEPTH_W = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_wr_en,
    input  logic        fifo_full,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_rd_data,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    input  logic        tx_req,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic        underrun
);

    localparam int CW = DEPTH_W + 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] PKT_LEN  = CW'(PKT_MAX);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SEND,
        WAIT_DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0] occ;
    logic [CW-1:0] len;
    logic [CW-1:0] rd_cnt;
    logic [TW-1:0] timer;

    logic wr_acc;
    logic full_go;
    logic tmo_go;
    logic rd_left;

    assign wr_acc  = fifo_wr_en & ~fifo_full;
    assign full_go = occ >= PKT_LEN;
    assign tmo_go  = (occ != '0) && (timer == TMO_LAST);
    assign rd_left = rd_cnt < len;

    assign busy        = state != IDLE;
    assign tx_data     = fifo_rd_data;
    assign tx_byte_num = 16'(len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        fifo_rd_en  = 1'b0;
        tx_start_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (full_go || tmo_go) begin
                    state_nx = START;
                end
            end
            START: begin
                tx_start_en = 1'b1;
                state_nx    = SEND;
            end
            SEND: begin
                fifo_rd_en = tx_req & ~fifo_empty & rd_left;
                // tx_done here is an early abort; leftovers stay queued
                if (tx_done) begin
                    state_nx = IDLE;
                end else if (fifo_rd_en && (rd_cnt == len - C_ONE)) begin
                    state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            unique case ({wr_acc, fifo_rd_en})
                2'b10:   occ <= occ + C_ONE;
                2'b01:   occ <= occ - C_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // Idle timer only runs while waiting in IDLE with data stored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state != IDLE || wr_acc) begin
            timer <= '0;
        end else if (occ != '0) begin
            timer <= timer + T_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len <= '0;
        end else if (state == IDLE) begin
            if (full_go) begin
                len <= PKT_LEN;
            end else if (tmo_go) begin
                len <= occ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
        end else if (state == START) begin
            rd_cnt <= '0;
        end else if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + C_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else begin
            underrun <= (state == SEND) & tx_req & fifo_empty & rd_left;
        end
    end

endmodule

// File: tb/tb_eth_fifo_pkt_reader.sv
// tb_eth_fifo_pkt_reader: randomized scenario bench with a queue FIFO model
// and a byte scoreboard; launch timing derived from write/done cycles.
module tb_eth_fifo_pkt_reader;

    localparam int PKT_MAX = 1024;
    localparam int TIMEOUT = 100;
    localparam int DEPTH_W = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_wr_en = 1'b0;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        busy;
    logic        underrun;

    logic [7:0]  wdata = 8'h00;
    logic        force_empty = 1'b0;

    eth_fifo_pkt_reader #(
        .PKT_MAX(PKT_MAX),
        .TIMEOUT(TIMEOUT),
        .DEPTH_W(DEPTH_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .tx_start_en(tx_start_en),
        .tx_byte_num(tx_byte_num),
        .tx_req(tx_req),
        .tx_data(tx_data),
        .tx_done(tx_done),
        .busy(busy),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model plus reference record of every accepted byte
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int fcnt;

    assign fifo_empty = (fcnt == 0) || force_empty;
    assign fifo_full  = fcnt >= 2048;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            exp_q.delete();
            fcnt <= 0;
            fifo_rd_data <= 8'h00;
        end else begin
            if (fifo_rd_en && fq.size() > 0)
                fifo_rd_data <= fq.pop_front();
            if (fifo_wr_en && !fifo_full) begin
                fq.push_back(wdata);
                exp_q.push_back(wdata);
            end
            fcnt <= fq.size();
        end
    end

    // Observation of DUT activity, sampled mid-cycle
    logic [7:0] got_q[$];
    logic rd_pend = 1'b0;
    int n_rd = 0;
    int n_rd_empty = 0;
    int n_start = 0;
    int n_unr = 0;
    int last_wr = 0;
    int start_cyc = 0;
    logic [15:0] start_len = 16'h0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rd_pend = 1'b0;
            got_q.delete();
        end else begin
            if (rd_pend) got_q.push_back(tx_data);
            rd_pend = fifo_rd_en;
            if (fifo_rd_en) begin
                n_rd++;
                if (fifo_empty) n_rd_empty++;
            end
            if (fifo_wr_en && !fifo_full) last_wr = cyc;
            if (tx_start_en) begin
                n_start++;
                start_cyc = cyc;
                start_len = tx_byte_num;
            end
            if (underrun) n_unr++;
        end
    end

    int checks = 0;
    int errors = 0;
    int gb = 0;
    int eb = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_n(input int n, input bit seq);
        for (int i = 0; i < n; i++) begin
            fifo_wr_en = 1'b1;
            wdata = seq ? 8'(i) : 8'($urandom);
            tick();
        end
        fifo_wr_en = 1'b0;
    endtask

    task automatic wait_start(input int bound, input int prev,
                              output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (n_start > prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_reads(input int target, input int bound,
                              output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (n_rd >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_done(output int dcyc);
        dcyc = cyc;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // Mismatch count of next n streamed bytes vs written bytes; -1 if short
    function automatic int data_mism(input int n);
        int m;
        if (got_q.size() < gb + n || exp_q.size() < eb + n) return -1;
        m = 0;
        for (int i = 0; i < n; i++)
            if (got_q[gb+i] !== exp_q[eb+i]) m++;
        return m;
    endfunction

    task automatic test_reset();
        int unsigned outs;
        rst_n = 1'b0;
        tx_req = 1'b1;
        repeat (3) tick();
        outs = {fifo_rd_en, tx_start_en, busy, underrun};
        checks++;
        if (outs !== 0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", outs);
        end
        checks++;
        if (tx_byte_num !== 16'd0) begin
            errors++;
            $display("FAIL reset_len: got %0d expected 0", tx_byte_num);
        end
        tx_req = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_full_packet();
        bit ok;
        int ns, nr, m, d;
        ns = n_start;
        nr = n_rd;
        tx_req = 1'b1;
        write_n(PKT_MAX, 1'b1);
        wait_start(10, ns, ok);
        checks++;
        if (!ok || start_cyc - last_wr != 2) begin
            errors++;
            $display("FAIL full_latency: got %0d expected 2",
                     start_cyc - last_wr);
        end
        checks++;
        if (start_len !== 16'(PKT_MAX)) begin
            errors++;
            $display("FAIL full_len: got %0d expected %0d",
                     start_len, PKT_MAX);
        end
        checks++;
        if (n_rd != nr || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_pre_send: reads %0d busy %b expected 0 1",
                     n_rd - nr, busy);
        end
        wait_reads(nr + PKT_MAX, PKT_MAX + 50, ok);
        repeat (4) tick();
        checks++;
        if (n_rd - nr != PKT_MAX) begin
            errors++;
            $display("FAIL full_rd_count: got %0d expected %0d",
                     n_rd - nr, PKT_MAX);
        end
        m = data_mism(PKT_MAX);
        checks++;
        if (m != 0) begin
            errors++;
            $display("FAIL full_data: got %0d bad bytes expected 0", m);
        end
        gb += PKT_MAX;
        eb += PKT_MAX;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL full_wait_busy: got %b expected 1", busy);
        end
        tx_req = 1'b0;
        pulse_done(d);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL full_done_idle: got %b expected 0", busy);
        end
        repeat (TIMEOUT + 20) tick();
        checks++;
        if (n_start != ns + 1) begin
            errors++;
            $display("FAIL full_occ_empty: got %0d launches expected 1",
                     n_start - ns);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int ns, nr, m, d, n;
        n = 10;
        ns = n_start;
        nr = n_rd;
        tx_req = 1'b0;
        write_n(n, 1'b0);
        wait_start(TIMEOUT + 20, ns, ok);
        checks++;
        if (!ok || start_cyc - last_wr != TIMEOUT + 1) begin
            errors++;
            $display("FAIL tmo_latency: got %0d expected %0d",
                     start_cyc - last_wr, TIMEOUT + 1);
        end
        checks++;
        if (start_len !== 16'(n)) begin
            errors++;
            $display("FAIL tmo_len: got %0d expected %0d", start_len, n);
        end
        tx_req = 1'b1;
        wait_reads(nr + n, 40, ok);
        repeat (3) tick();
        tx_req = 1'b0;
        m = data_mism(n);
        checks++;
        if (n_rd - nr != n || m != 0) begin
            errors++;
            $display("FAIL tmo_data: reads %0d bad %0d expected %0d 0",
                     n_rd - nr, m, n);
        end
        gb += n;
        eb += n;
        pulse_done(d);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_done_idle: got %b expected 0", busy);
        end
    endtask

    task automatic test_concurrent();
        bit ok;
        int ns, nr, m, d, extra;
        extra = 300;
        ns = n_start;
        nr = n_rd;
        tx_req = 1'b0;
        write_n(PKT_MAX, 1'b1);
        wait_start(10, ns, ok);
        tx_req = 1'b1;
        write_n(extra, 1'b0);
        wait_reads(nr + PKT_MAX, PKT_MAX, ok);
        repeat (3) tick();
        checks++;
        if (n_rd - nr != PKT_MAX) begin
            errors++;
            $display("FAIL conc_rd_count: got %0d expected %0d",
                     n_rd - nr, PKT_MAX);
        end
        m = data_mism(PKT_MAX);
        checks++;
        if (m != 0) begin
            errors++;
            $display("FAIL conc_data: got %0d bad bytes expected 0", m);
        end
        gb += PKT_MAX;
        eb += PKT_MAX;
        pulse_done(d);
        ns = n_start;
        nr = n_rd;
        wait_start(TIMEOUT + 20, ns, ok);
        checks++;
        if (!ok || start_len !== 16'(extra)) begin
            errors++;
            $display("FAIL conc_tmo_len: got %0d expected %0d",
                     start_len, extra);
        end
        checks++;
        if (start_cyc != d + TIMEOUT + 1) begin
            errors++;
            $display("FAIL conc_tmo_latency: got %0d expected %0d",
                     start_cyc - d, TIMEOUT + 1);
        end
        wait_reads(nr + extra, extra + 50, ok);
        repeat (3) tick();
        m = data_mism(extra);
        checks++;
        if (n_rd - nr != extra || m != 0) begin
            errors++;
            $display("FAIL conc_tail: reads %0d bad %0d expected %0d 0",
                     n_rd - nr, m, extra);
        end
        gb += extra;
        eb += extra;
        tx_req = 1'b0;
        pulse_done(d);
    endtask

    task automatic test_over_request();
        bit ok;
        int ns, nr, nu, m, d, n;
        n = 10;
        ns = n_start;
        nr = n_rd;
        nu = n_unr;
        tx_req = 1'b0;
        write_n(n, 1'b0);
        wait_start(TIMEOUT + 20, ns, ok);
        tx_req = 1'b1;
        repeat (15) tick();
        tx_req = 1'b0;
        repeat (2) tick();
        checks++;
        if (!ok || n_rd - nr != n || n_unr != nu) begin
            errors++;
            $display("FAIL over_req: reads %0d unr %0d expected %0d 0",
                     n_rd - nr, n_unr - nu, n);
        end
        m = data_mism(n);
        checks++;
        if (m != 0) begin
            errors++;
            $display("FAIL over_data: got %0d bad bytes expected 0", m);
        end
        gb += n;
        eb += n;
        pulse_done(d);
    endtask

    task automatic test_underrun();
        bit ok;
        int ns, nr, nu, ne, m, d, n;
        n = 10;
        ns = n_start;
        nr = n_rd;
        nu = n_unr;
        ne = n_rd_empty;
        tx_req = 1'b0;
        write_n(n, 1'b0);
        wait_start(TIMEOUT + 20, ns, ok);
        tx_req = 1'b1;
        repeat (3) tick();
        force_empty = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL unr_no_read: got %b expected 0", fifo_rd_en);
        end
        checks++;
        if (n_rd - nr != 3) begin
            errors++;
            $display("FAIL unr_rd_cnt: got %0d expected 3", n_rd - nr);
        end
        tick();
        force_empty = 1'b0;
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL unr_pulse: got %b expected 1", underrun);
        end
        tick();
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL unr_one_cycle: got %b expected 0", underrun);
        end
        wait_reads(nr + n, 30, ok);
        repeat (3) tick();
        tx_req = 1'b0;
        m = data_mism(n);
        checks++;
        if (n_rd - nr != n || m != 0 || n_unr - nu != 1) begin
            errors++;
            $display("FAIL unr_resume: reads %0d bad %0d unr %0d exp %0d 0 1",
                     n_rd - nr, m, n_unr - nu, n);
        end
        checks++;
        if (n_rd_empty != ne) begin
            errors++;
            $display("FAIL unr_read_empty: got %0d expected 0",
                     n_rd_empty - ne);
        end
        gb += n;
        eb += n;
        pulse_done(d);
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        int ns, nr, m, d;
        int unsigned outs;
        ns = n_start;
        nr = n_rd;
        tx_req = 1'b0;
        write_n(PKT_MAX, 1'b1);
        wait_start(10, ns, ok);
        tx_req = 1'b1;
        wait_reads(nr + 500, 600, ok);
        rst_n = 1'b0;
        #1;
        outs = {fifo_rd_en, tx_start_en, busy, underrun};
        checks++;
        if (!ok || outs !== 0 || tx_byte_num !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_outs: got %b len %0d expected 0000 0",
                     outs, tx_byte_num);
        end
        repeat (2) tick();
        tx_req = 1'b0;
        rst_n = 1'b1;
        gb = 0;
        eb = 0;
        tick();
        ns = n_start;
        nr = n_rd;
        write_n(PKT_MAX, 1'b1);
        wait_start(10, ns, ok);
        checks++;
        if (!ok || start_cyc - last_wr != 2 ||
            start_len !== 16'(PKT_MAX)) begin
            errors++;
            $display("FAIL rst_relaunch: lat %0d len %0d expected 2 %0d",
                     start_cyc - last_wr, start_len, PKT_MAX);
        end
        tx_req = 1'b1;
        wait_reads(nr + PKT_MAX, PKT_MAX + 50, ok);
        repeat (3) tick();
        tx_req = 1'b0;
        m = data_mism(PKT_MAX);
        checks++;
        if (n_rd - nr != PKT_MAX || m != 0) begin
            errors++;
            $display("FAIL rst_data: reads %0d bad %0d expected %0d 0",
                     n_rd - nr, m, PKT_MAX);
        end
        pulse_done(d);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_done_idle: got %b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_timeout();
        test_concurrent();
        test_over_request();
        test_underrun();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
